// File: rtl/lane_write_sequencer_if.sv
// Handshake bus for lane_write_sequencer: upstream word stream in, registered lane write out.
// master = upstream/consumer side, slave = the sequencer.
interface lane_write_sequencer_if #(
    parameter int DATA_W = 8,
    parameter int IDX_W  = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [IDX_W-1:0]  lane_idx;
    logic              wr_en;
    logic [DATA_W-1:0] wr_data;

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  lane_idx,
        input  wr_en,
        input  wr_data
    );

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output lane_idx,
        output wr_en,
        output wr_data
    );
endinterface

// File: rtl/lane_write_sequencer.sv
// Assigns a burst of upstream words to compute-tile lanes in order, one registered write per word.
// Optional lane skipping is enabled with `define LANE_SKIP_MASK_EN (adds the lane_mask port).
module lane_write_sequencer #(
    parameter int DATA_W    = 8,
    parameter int IDX_W     = 4,
    parameter int NUM_LANES = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
`ifdef LANE_SKIP_MASK_EN
    input  logic [NUM_LANES-1:0] lane_mask,
`endif
    input  logic [IDX_W:0]       count,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    lane_write_sequencer_if.slave bus
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_LOAD = 1'b1
    } state_t;

    localparam logic [IDX_W:0] MAX_CNT = (IDX_W + 1)'(NUM_LANES);

    state_t              state_q, state_d;
    logic [IDX_W:0]      remaining_q, remaining_d;
    logic [IDX_W-1:0]    ptr_q, ptr_d;
    logic [IDX_W-1:0]    lane_idx_q, lane_idx_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                wr_en_q, wr_en_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                in_ready_s;
    logic                accept_s;
    logic                last_s;
    logic                start_ok_s;
    logic [IDX_W:0]      count_clamped_s;
    logic [IDX_W-1:0]    first_lane_s;
    logic [IDX_W-1:0]    next_lane_s;

`ifdef LANE_SKIP_MASK_EN
    logic [NUM_LANES-1:0] mask_q, mask_d;

    // Next enabled lane strictly after cur, wrapping; searching from the top lane yields the lowest set bit.
    function automatic logic [IDX_W-1:0] next_enabled(input logic [NUM_LANES-1:0] mask,
                                                      input logic [IDX_W-1:0]     cur);
        logic [IDX_W-1:0] res;
        logic [IDX_W-1:0] cand;
        logic             found;
        res   = cur;
        found = 1'b0;
        for (int i = 1; i <= NUM_LANES; i++) begin
            cand = cur + IDX_W'(i);
            if (!found && mask[cand]) begin
                res   = cand;
                found = 1'b1;
            end else begin
                res   = res;
            end
        end
        return res;
    endfunction

    assign start_ok_s   = start & ~abort & (lane_mask != {NUM_LANES{1'b0}});
    assign first_lane_s = next_enabled(lane_mask, IDX_W'(NUM_LANES - 1));
    assign next_lane_s  = next_enabled(mask_q, ptr_q);
`else
    assign start_ok_s   = start & ~abort;
    assign first_lane_s = {IDX_W{1'b0}};
    assign next_lane_s  = ptr_q + {{(IDX_W-1){1'b0}}, 1'b1};
`endif

    assign count_clamped_s = ((count == {(IDX_W+1){1'b0}}) || (count > MAX_CNT)) ? MAX_CNT : count;
    assign last_s          = (remaining_q == {{IDX_W{1'b0}}, 1'b1});

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_ok_s) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (abort || (accept_s && last_s)) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_LOAD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: abort masks ready combinationally so no word slips in during the abort cycle
    always_comb begin
        in_ready_s = 1'b0;
        case (state_q)
            ST_IDLE: in_ready_s = 1'b0;
            ST_LOAD: in_ready_s = ~abort;
            default: in_ready_s = 1'b0;
        endcase
        accept_s = in_ready_s & bus.in_valid;
    end

    // Datapath next values: burst setup, lane pointer advance and the registered write
    always_comb begin
        remaining_d = remaining_q;
        ptr_d       = ptr_q;
        lane_idx_d  = lane_idx_q;
        wr_data_d   = wr_data_q;
        wr_en_d     = accept_s;
        done_d      = accept_s & last_s;
        busy_d      = (state_d == ST_LOAD) | (accept_s & last_s);
`ifdef LANE_SKIP_MASK_EN
        mask_d      = mask_q;
`endif
        if ((state_q == ST_IDLE) && start_ok_s) begin
            remaining_d = count_clamped_s;
            ptr_d       = first_lane_s;
`ifdef LANE_SKIP_MASK_EN
            mask_d      = lane_mask;
`endif
        end else if (accept_s) begin
            remaining_d = remaining_q - {{IDX_W{1'b0}}, 1'b1};
            ptr_d       = next_lane_s;
            lane_idx_d  = ptr_q;
            wr_data_d   = bus.in_data;
        end else begin
            remaining_d = remaining_q;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remaining_q <= {(IDX_W+1){1'b0}};
            ptr_q       <= {IDX_W{1'b0}};
            lane_idx_q  <= {IDX_W{1'b0}};
            wr_data_q   <= {DATA_W{1'b0}};
            wr_en_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef LANE_SKIP_MASK_EN
            mask_q      <= {NUM_LANES{1'b0}};
`endif
        end else begin
            remaining_q <= remaining_d;
            ptr_q       <= ptr_d;
            lane_idx_q  <= lane_idx_d;
            wr_data_q   <= wr_data_d;
            wr_en_q     <= wr_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef LANE_SKIP_MASK_EN
            mask_q      <= mask_d;
`endif
        end
    end

    assign bus.in_ready = in_ready_s;
    assign bus.lane_idx = lane_idx_q;
    assign bus.wr_en    = wr_en_q;
    assign bus.wr_data  = wr_data_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_lane_write_sequencer.sv
// Randomized and directed bench for lane_write_sequencer against a burst-level reference model.
// The model keeps the burst as a list of enabled lanes plus a word index.
module tb_lane_write_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [4:0]  count;
    logic        abort;
    logic        busy;
    logic        done;
    logic [15:0] mask_v;

    lane_write_sequencer_if #(.DATA_W(8), .IDX_W(4)) bus ();

    lane_write_sequencer #(.DATA_W(8), .IDX_W(4), .NUM_LANES(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
`ifdef LANE_SKIP_MASK_EN
        .lane_mask (mask_v),
`endif
        .count     (count),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // reference model state
    bit         m_active;
    int         m_k;
    int         m_n;
    int         lanes[$];
    logic [3:0] e_lane;
    logic [7:0] e_data;
    logic       e_wr;
    logic       e_done;
    logic       e_busy;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 1'b0;
        m_k      = 0;
        m_n      = 0;
        e_lane   = 4'd0;
        e_data   = 8'd0;
        e_wr     = 1'b0;
        e_done   = 1'b0;
        e_busy   = 1'b0;
    endtask

    task automatic check_outputs(input string ph);
        check_eq({ph, "_wr_en"},    {31'd0, bus.wr_en},   {31'd0, e_wr});
        check_eq({ph, "_lane_idx"}, {28'd0, bus.lane_idx}, {28'd0, e_lane});
        check_eq({ph, "_wr_data"},  {24'd0, bus.wr_data},  {24'd0, e_data});
        check_eq({ph, "_done"},     {31'd0, done},        {31'd0, e_done});
        check_eq({ph, "_busy"},     {31'd0, busy},        {31'd0, e_busy});
    endtask

    // One clock cycle: drive inputs, check ready, advance the model, check registered outputs.
    task automatic step(input bit s, input logic [4:0] c, input bit a, input bit v, input logic [7:0] d);
        bit mask_ok;
        bit acc;
        bit next_active;
        int n;
        @(negedge clk);
        start       = s;
        count       = c;
        abort       = a;
        bus.in_valid = v;
        bus.in_data  = d;
        #1;
        check_eq("in_ready", {31'd0, bus.in_ready}, {31'd0, (m_active && !a)});
`ifdef LANE_SKIP_MASK_EN
        mask_ok = (mask_v != 16'd0);
`else
        mask_ok = 1'b1;
`endif
        acc         = m_active && !a && v;
        next_active = m_active;
        e_wr        = acc;
        e_done      = 1'b0;
        if (!m_active) begin
            if (s && !a && mask_ok) begin
                n = int'(c);
                m_n = (n == 0 || n > 16) ? 16 : n;
                m_k = 0;
                lanes.delete();
                for (int i = 0; i < 16; i++) begin
`ifdef LANE_SKIP_MASK_EN
                    if (mask_v[i]) lanes.push_back(i);
`else
                    lanes.push_back(i);
`endif
                end
                next_active = 1'b1;
            end
        end else if (a) begin
            next_active = 1'b0;
        end else if (acc) begin
            e_lane = 4'(lanes[m_k % lanes.size()]);
            e_data = d;
            if (m_k == m_n - 1) begin
                e_done      = 1'b1;
                next_active = 1'b0;
            end
            m_k++;
        end
        m_active = next_active;
        e_busy   = next_active || e_done;
        @(posedge clk);
        #1;
        check_outputs("cyc");
    endtask

    task automatic burst(input logic [4:0] c, input int words);
        step(1'b1, c, 1'b0, 1'b0, 8'd0);
        for (int i = 0; i < words; i++) step(1'b0, 5'd0, 1'b0, 1'b1, 8'($urandom));
        step(1'b0, 5'd0, 1'b0, 1'b0, 8'd0);
    endtask

    initial begin
        rst_n        = 1'b0;
        start        = 1'b0;
        count        = 5'd0;
        abort        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'd0;
        mask_v       = 16'hFFFF;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check_outputs("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // count=4 with words A0..A3 back to back
        step(1'b1, 5'd4, 1'b0, 1'b0, 8'd0);
        for (int i = 0; i < 4; i++) step(1'b0, 5'd0, 1'b0, 1'b1, 8'hA0 + 8'(i));
        step(1'b0, 5'd0, 1'b0, 1'b0, 8'd0);
        // count=0 and count=20 both clamp to 16
        burst(5'd0, 16);
        burst(5'd20, 20);
        // gapped valid with count=3
        step(1'b1, 5'd3, 1'b0, 1'b0, 8'd0);
        for (int i = 0; i < 6; i++) step(1'b0, 5'd0, 1'b0, (i % 2 == 0), 8'h30 + 8'(i));
        // abort after two of five words, with valid held in the abort cycle
        step(1'b1, 5'd5, 1'b0, 1'b0, 8'd0);
        step(1'b0, 5'd0, 1'b0, 1'b1, 8'h51);
        step(1'b0, 5'd0, 1'b0, 1'b1, 8'h52);
        step(1'b0, 5'd0, 1'b1, 1'b1, 8'h53);
        step(1'b0, 5'd0, 1'b0, 1'b0, 8'h00);
        burst(5'd2, 2);
        // start together with abort in IDLE, and start during LOAD
        step(1'b1, 5'd3, 1'b1, 1'b0, 8'd0);
        step(1'b1, 5'd2, 1'b0, 1'b0, 8'd0);
        step(1'b1, 5'd9, 1'b0, 1'b1, 8'h61);
        step(1'b1, 5'd9, 1'b0, 1'b1, 8'h62);
        // back-to-back start in the done cycle
        step(1'b1, 5'd1, 1'b0, 1'b0, 8'd0);
        step(1'b0, 5'd0, 1'b0, 1'b1, 8'h71);
        step(1'b1, 5'd1, 1'b0, 1'b0, 8'd0);
        step(1'b0, 5'd0, 1'b0, 1'b1, 8'h72);
        step(1'b0, 5'd0, 1'b0, 1'b0, 8'h00);
`ifdef LANE_SKIP_MASK_EN
        mask_v = 16'h8421;
        burst(5'd6, 6);
        mask_v = 16'h0000;
        step(1'b1, 5'd4, 1'b0, 1'b0, 8'd0);
        step(1'b0, 5'd0, 1'b0, 1'b1, 8'h99);
        mask_v = 16'hFFFF;
`endif

        // randomized traffic
        for (int it = 0; it < 1500; it++) begin
            bit s;
            s = ($urandom_range(0, 7) == 0);
`ifdef LANE_SKIP_MASK_EN
            if (s && !m_active) mask_v = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom);
`endif
            step(s, 5'($urandom), ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0), 8'($urandom));
        end

        // asynchronous reset in the middle of a burst
        step(1'b1, 5'd10, 1'b0, 1'b0, 8'd0);
        for (int i = 0; i < 3; i++) step(1'b0, 5'd0, 1'b0, 1'b1, 8'hC0 + 8'(i));
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_eq("midrst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        check_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 5'd0, 1'b0, 1'b1, 8'hEE);
        burst(5'd3, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
